// File: rtl/titan_lsu.sv
// Load/store unit: turns MEM-stage access flags into one Wishbone-classic
// data-bus cycle and returns extended load data, misalignment and bus faults.
module titan_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdat_i,
  input  logic        lsu_mread_i,
  input  logic        lsu_mwrite_i,
  input  logic        lsu_mbyte_i,
  input  logic        lsu_mhw_i,
  input  logic        lsu_mword_i,
  input  logic        lsu_munsigned_i,
  input  logic        lsu_kill_i,
  input  logic        lsu_next_i,
  output logic [31:0] lsu_rdat_o,
  output logic        lsu_cyc_o,
  output logic        lsu_ack_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_fault_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_we_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, dat_q, rdat_q;
  logic [3:0]  sel_q;
  logic        bus_q, we_q, fault_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  off_q;
  logic        word_q, half_q, uns_q;

  logic        req, is_word, is_half, misaligned, start;
  logic        timeout, bus_resp, fault_now;
  logic [3:0]  sel_d;
  logic [31:0] store_dat, load_ext;

  // Size priority is word > half > byte; anything else is a byte access.
  assign req        = lsu_mread_i | lsu_mwrite_i;
  assign is_word    = lsu_mword_i;
  assign is_half    = ~lsu_mword_i & lsu_mhw_i;
  assign misaligned = (is_word & (|lsu_addr_i[1:0])) | (is_half & lsu_addr_i[0]);
  assign start      = (state_q == S_IDLE) & req & ~misaligned & ~lsu_kill_i;

  assign timeout   = (cnt_q == CNT_LAST);
  assign bus_resp  = dwbm_ack_i | dwbm_err_i | timeout;
  // A real ack in the last timeout cycle still counts as success; err never does.
  assign fault_now = dwbm_err_i | (timeout & ~dwbm_ack_i);

  always_comb begin
    sel_d = 4'b0001 << lsu_addr_i[1:0];
    if (is_word)
      sel_d = 4'b1111;
    else if (is_half)
      sel_d = 4'b0011 << {lsu_addr_i[1], 1'b0};
  end

  // Replicate narrow store data across every lane so sel alone picks the bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
    assign store_dat[8*gi +: 8] = is_word ? lsu_wdat_i[8*gi +: 8] :
                                  is_half ? lsu_wdat_i[8*(gi%2) +: 8] :
                                            lsu_wdat_i[7:0];
  end

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] off,
                                              input logic w, input logic h, input logic u);
    logic [31:0] bsh, hsh, r;
    bsh = d >> {off, 3'b000};
    hsh = d >> {off[1], 4'b0000};
    if (w)
      r = d;
    else if (h)
      r = {{16{hsh[15] & ~u}}, hsh[15:0]};
    else
      r = {{24{bsh[7] & ~u}}, bsh[7:0]};
    return r;
  endfunction

  assign load_ext = extend_load(dwbm_dat_i, off_q, word_q, half_q, uns_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUS;
      S_BUS: begin
        if (lsu_kill_i)
          state_d = bus_resp ? S_IDLE : S_DRAIN;
        else if (bus_resp)
          state_d = S_DONE;
      end
      S_DONE:  if (lsu_next_i | lsu_kill_i) state_d = S_IDLE;
      S_DRAIN: if (bus_resp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lsu_cyc_o        = 1'b0;
    lsu_ack_o        = 1'b0;
    lsu_misaligned_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        lsu_cyc_o        = req & ~misaligned;
        lsu_misaligned_o = req & misaligned;
      end
      S_BUS:   lsu_cyc_o = 1'b1;
      S_DONE: begin
        lsu_cyc_o = 1'b1;
        lsu_ack_o = 1'b1;
      end
      S_DRAIN: lsu_cyc_o = req;
      default: lsu_cyc_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      bus_q   <= 1'b0;
      cnt_q   <= '0;
      off_q   <= '0;
      word_q  <= 1'b0;
      half_q  <= 1'b0;
      uns_q   <= 1'b0;
      rdat_q  <= '0;
      fault_q <= 1'b0;
    end else if (start) begin
      addr_q <= {lsu_addr_i[31:2], 2'b00};
      dat_q  <= store_dat;
      sel_q  <= sel_d;
      we_q   <= lsu_mwrite_i;
      bus_q  <= 1'b1;
      cnt_q  <= '0;
      off_q  <= lsu_addr_i[1:0];
      word_q <= is_word;
      half_q <= is_half;
      uns_q  <= lsu_munsigned_i;
    end else if (state_q == S_BUS || state_q == S_DRAIN) begin
      if (bus_resp) begin
        bus_q <= 1'b0;
        // Killed or draining accesses leave the previous result untouched.
        if (state_q == S_BUS && !lsu_kill_i) begin
          fault_q <= fault_now;
          rdat_q  <= (fault_now | we_q) ? 32'h0 : load_ext;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dwbm_addr_o = addr_q;
  assign dwbm_dat_o  = dat_q;
  assign dwbm_sel_o  = sel_q;
  assign dwbm_we_o   = we_q;
  assign dwbm_cyc_o  = bus_q;
  assign dwbm_stb_o  = bus_q;
  assign lsu_rdat_o  = rdat_q;
  assign lsu_fault_o = fault_q;

endmodule

// File: tb/tb_titan_lsu.sv
// Directed bench for titan_lsu: vector table of single accesses plus
// hand-written timeout, kill/drain and reset-mid-cycle sequences.
module tb_titan_lsu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] lsu_addr_i, lsu_wdat_i;
  logic        lsu_mread_i, lsu_mwrite_i, lsu_mbyte_i, lsu_mhw_i, lsu_mword_i;
  logic        lsu_munsigned_i, lsu_kill_i, lsu_next_i;
  logic [31:0] lsu_rdat_o;
  logic        lsu_cyc_o, lsu_ack_o, lsu_misaligned_o, lsu_fault_o;
  logic [31:0] dwbm_addr_o, dwbm_dat_o;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_cyc_o, dwbm_stb_o, dwbm_we_o;
  logic [31:0] dwbm_dat_i;
  logic        dwbm_ack_i, dwbm_err_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  titan_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdat_i(lsu_wdat_i),
    .lsu_mread_i(lsu_mread_i), .lsu_mwrite_i(lsu_mwrite_i),
    .lsu_mbyte_i(lsu_mbyte_i), .lsu_mhw_i(lsu_mhw_i), .lsu_mword_i(lsu_mword_i),
    .lsu_munsigned_i(lsu_munsigned_i), .lsu_kill_i(lsu_kill_i), .lsu_next_i(lsu_next_i),
    .lsu_rdat_o(lsu_rdat_o), .lsu_cyc_o(lsu_cyc_o), .lsu_ack_o(lsu_ack_o),
    .lsu_misaligned_o(lsu_misaligned_o), .lsu_fault_o(lsu_fault_o),
    .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
    .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_we_o(dwbm_we_o),
    .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        rd, wr, b, h, w, u, err;
    int          dly;
    logic [31:0] bdat;
    logic [3:0]  sel;
    logic [31:0] dato;
    logic        mis;
    logic [31:0] rdat;
    logic        flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdat,
                              input logic rd, input logic wr, input logic b, input logic h,
                              input logic w, input logic u, input logic err, input int dly,
                              input logic [31:0] bdat, input logic [3:0] sel,
                              input logic [31:0] dato, input logic mis,
                              input logic [31:0] rdat, input logic flt);
    vec_t v;
    v.addr = addr; v.wdat = wdat; v.rd = rd; v.wr = wr; v.b = b; v.h = h; v.w = w;
    v.u = u; v.err = err; v.dly = dly; v.bdat = bdat; v.sel = sel; v.dato = dato;
    v.mis = mis; v.rdat = rdat; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_req();
    lsu_addr_i = '0; lsu_wdat_i = '0;
    lsu_mread_i = 0; lsu_mwrite_i = 0; lsu_mbyte_i = 0; lsu_mhw_i = 0;
    lsu_mword_i = 0; lsu_munsigned_i = 0; lsu_kill_i = 0; lsu_next_i = 0;
  endtask

  task automatic drive_lw(input logic [31:0] a);
    lsu_addr_i = a; lsu_wdat_i = '0; lsu_mread_i = 1; lsu_mwrite_i = 0;
    lsu_mbyte_i = 0; lsu_mhw_i = 0; lsu_mword_i = 1; lsu_munsigned_i = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    lsu_addr_i = v.addr; lsu_wdat_i = v.wdat; lsu_mread_i = v.rd; lsu_mwrite_i = v.wr;
    lsu_mbyte_i = v.b; lsu_mhw_i = v.h; lsu_mword_i = v.w; lsu_munsigned_i = v.u;
    lsu_kill_i = 0; lsu_next_i = 0;
    #1;
    chk($sformatf("v%0d misaligned", idx), {31'd0, lsu_misaligned_o}, {31'd0, v.mis});
    chk($sformatf("v%0d req_cyc", idx), {31'd0, lsu_cyc_o}, {31'd0, !v.mis});
    if (v.mis) begin
      @(negedge clk); #1;
      chk($sformatf("v%0d no_bus", idx), {31'd0, dwbm_cyc_o}, 32'd0);
      clear_req();
      $display("vec %0d addr=0x%08h misaligned", idx, v.addr);
      return;
    end
    for (int c = 0; c <= v.dly; c++) begin
      @(negedge clk);
      if (c == v.dly) begin
        dwbm_ack_i = 1; dwbm_err_i = v.err; dwbm_dat_i = v.bdat;
      end
      #1;
      chk($sformatf("v%0d stb", idx), {30'd0, dwbm_cyc_o, dwbm_stb_o}, 32'd3);
      chk($sformatf("v%0d ack_busy", idx), {31'd0, lsu_ack_o}, 32'd0);
      if (c == 0) begin
        chk($sformatf("v%0d addr", idx), dwbm_addr_o, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d sel", idx), {28'd0, dwbm_sel_o}, {28'd0, v.sel});
        chk($sformatf("v%0d dato", idx), dwbm_dat_o, v.dato);
        chk($sformatf("v%0d we", idx), {31'd0, dwbm_we_o}, {31'd0, v.wr});
      end
    end
    @(negedge clk);
    dwbm_ack_i = 0; dwbm_err_i = 0; dwbm_dat_i = '0;
    #1;
    chk($sformatf("v%0d ack", idx), {31'd0, lsu_ack_o}, 32'd1);
    chk($sformatf("v%0d cyc_done", idx), {31'd0, lsu_cyc_o}, 32'd1);
    chk($sformatf("v%0d rdat", idx), lsu_rdat_o, v.rdat);
    chk($sformatf("v%0d fault", idx), {31'd0, lsu_fault_o}, {31'd0, v.flt});
    chk($sformatf("v%0d bus_closed", idx), {31'd0, dwbm_cyc_o}, 32'd0);
    @(negedge clk); #1;
    chk($sformatf("v%0d ack_held", idx), {31'd0, lsu_ack_o}, 32'd1);
    chk($sformatf("v%0d no_reissue", idx), {31'd0, dwbm_cyc_o}, 32'd0);
    lsu_next_i = 1;
    @(negedge clk);
    clear_req();
    #1;
    chk($sformatf("v%0d ack_off", idx), {31'd0, lsu_ack_o}, 32'd0);
    chk($sformatf("v%0d bus_idle", idx), {31'd0, dwbm_cyc_o}, 32'd0);
    $display("vec %0d addr=0x%08h rdat=0x%08h fault=%0b", idx, v.addr, lsu_rdat_o, lsu_fault_o);
  endtask

  initial begin
    rst_i = 1; clear_req();
    dwbm_dat_i = '0; dwbm_ack_i = 0; dwbm_err_i = 0;

    //           addr       wdat        rd wr b  h  w  u  er dly bdat        sel    dato        mis rdat        flt
    vecs.push_back(mk(32'h100, 32'h0,        1, 0, 0, 0, 1, 0, 0, 2, 32'hDEADBEEF, 4'hF, 32'h0,        0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(32'h103, 32'h0,        1, 0, 1, 0, 0, 0, 0, 1, 32'h80123456, 4'h8, 32'h0,        0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(32'h103, 32'h0,        1, 0, 1, 0, 0, 1, 0, 1, 32'h80123456, 4'h8, 32'h0,        0, 32'h00000080, 0));
    vecs.push_back(mk(32'h102, 32'h0,        1, 0, 0, 1, 0, 0, 0, 0, 32'h80123456, 4'hC, 32'h0,        0, 32'hFFFF8012, 0));
    vecs.push_back(mk(32'h102, 32'h0000ABCD, 0, 1, 0, 1, 0, 0, 0, 1, 32'h55555555, 4'hC, 32'hABCDABCD, 0, 32'h0,        0));
    vecs.push_back(mk(32'h101, 32'h0,        1, 0, 0, 0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        1, 32'h0,        0));
    vecs.push_back(mk(32'h101, 32'h0,        1, 0, 0, 1, 0, 0, 0, 0, 32'h0,        4'h0, 32'h0,        1, 32'h0,        0));
    vecs.push_back(mk(32'h100, 32'h0,        1, 0, 0, 1, 0, 1, 0, 1, 32'h80128765, 4'h3, 32'h0,        0, 32'h00008765, 0));
    vecs.push_back(mk(32'h101, 32'h12345678, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,        4'h2, 32'h78787878, 0, 32'h0,        0));
    vecs.push_back(mk(32'h104, 32'hCAFEF00D, 0, 1, 0, 0, 1, 0, 0, 2, 32'h0,        4'hF, 32'hCAFEF00D, 0, 32'h0,        0));
    vecs.push_back(mk(32'h108, 32'h0,        1, 0, 0, 0, 1, 0, 1, 0, 32'h12345678, 4'hF, 32'h0,        0, 32'h0,        1));
    vecs.push_back(mk(32'h101, 32'h0,        1, 0, 1, 0, 0, 0, 0, 0, 32'h0000FF00, 4'h2, 32'h0,        0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(32'h10C, 32'h01020304, 1, 1, 0, 0, 1, 0, 0, 1, 32'h0,        4'hF, 32'h01020304, 0, 32'h0,        0));
    vecs.push_back(mk(32'h102, 32'h0,        1, 0, 0, 1, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        1, 32'h0,        0));
    vecs.push_back(mk(32'h100, 32'h0,        1, 0, 1, 1, 0, 0, 0, 0, 32'h00007FFF, 4'h3, 32'h0,        0, 32'h00007FFF, 0));

    repeat (2) @(negedge clk);
    #1;
    chk("rst dwbm_cyc", {31'd0, dwbm_cyc_o}, 32'd0);
    chk("rst dwbm_addr", dwbm_addr_o, 32'd0);
    chk("rst rdat", lsu_rdat_o, 32'd0);
    chk("rst ack_fault", {30'd0, lsu_ack_o, lsu_fault_o}, 32'd0);
    chk("rst lsu_cyc", {31'd0, lsu_cyc_o}, 32'd0);
    $display("reset checked");
    @(negedge clk); rst_i = 0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Timeout: no response for 4 bus cycles.
    @(negedge clk); drive_lw(32'h110);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("to stb c%0d", c), {31'd0, dwbm_stb_o}, 32'd1);
      chk($sformatf("to noack c%0d", c), {31'd0, lsu_ack_o}, 32'd0);
    end
    @(negedge clk); #1;
    chk("to ack", {31'd0, lsu_ack_o}, 32'd1);
    chk("to fault", {31'd0, lsu_fault_o}, 32'd1);
    chk("to rdat", lsu_rdat_o, 32'd0);
    chk("to bus_dropped", {31'd0, dwbm_cyc_o}, 32'd0);
    lsu_next_i = 1;
    @(negedge clk); clear_req();
    $display("timeout sequence fault=%0b", lsu_fault_o);

    // Kill in BUS, then a new request stalls until the drain completes.
    @(negedge clk); drive_lw(32'h200);
    @(negedge clk); clear_req(); lsu_kill_i = 1;
    @(negedge clk); lsu_kill_i = 0; #1;
    chk("kill bus_open", {31'd0, dwbm_cyc_o}, 32'd1);
    chk("kill addr", dwbm_addr_o, 32'h200);
    chk("kill no_ack", {31'd0, lsu_ack_o}, 32'd0);
    drive_lw(32'h300); #1;
    chk("drain stall", {31'd0, lsu_cyc_o}, 32'd1);
    @(negedge clk); dwbm_ack_i = 1; dwbm_dat_i = 32'hAAAA5555; #1;
    chk("drain no_ack", {31'd0, lsu_ack_o}, 32'd0);
    @(negedge clk); dwbm_ack_i = 0; dwbm_dat_i = '0; #1;
    chk("drain closed", {31'd0, dwbm_cyc_o}, 32'd0);
    chk("drain no_ack2", {31'd0, lsu_ack_o}, 32'd0);
    chk("drain stall2", {31'd0, lsu_cyc_o}, 32'd1);
    @(negedge clk); #1;
    chk("reissue cyc", {31'd0, dwbm_cyc_o}, 32'd1);
    chk("reissue addr", dwbm_addr_o, 32'h300);
    dwbm_ack_i = 1; dwbm_dat_i = 32'h11223344;
    @(negedge clk); dwbm_ack_i = 0; dwbm_dat_i = '0; #1;
    chk("reissue ack", {31'd0, lsu_ack_o}, 32'd1);
    chk("reissue rdat", lsu_rdat_o, 32'h11223344);
    lsu_next_i = 1;
    @(negedge clk); clear_req();
    $display("kill/drain sequence rdat=0x%08h", lsu_rdat_o);

    // Reset while the bus cycle is open.
    @(negedge clk); drive_lw(32'h400);
    @(negedge clk); #1;
    chk("pre-rst bus", {31'd0, dwbm_cyc_o}, 32'd1);
    rst_i = 1; clear_req(); #1;
    chk("rst_mid cyc", {30'd0, dwbm_cyc_o, dwbm_stb_o}, 32'd0);
    chk("rst_mid addr", dwbm_addr_o, 32'd0);
    chk("rst_mid lsu", {30'd0, lsu_cyc_o, lsu_ack_o}, 32'd0);
    @(negedge clk); rst_i = 0;
    $display("reset-mid-bus sequence dwbm_cyc=%0b", dwbm_cyc_o);
    run_vec(vecs[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
